// File: rtl/issue_queue_slots.sv
// Reservation-station slot storage: dispatch allocation, tag wakeup and
// grant-driven issue, feeding the external age-matrix selector.
module issue_queue_slot #(
    parameter int TAG_W     = 6,
    parameter int PAYLOAD_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 alloc,
    input  logic                 issue,
    input  logic [PAYLOAD_W-1:0] disp_payload,
    input  logic [TAG_W-1:0]     disp_src1_tag,
    input  logic                 disp_src1_rdy,
    input  logic [TAG_W-1:0]     disp_src2_tag,
    input  logic                 disp_src2_rdy,
    input  logic                 wb_valid,
    input  logic [TAG_W-1:0]     wb_tag,
    output logic                 valid,
    output logic                 ready,
    output logic [PAYLOAD_W-1:0] payload
);
    logic [TAG_W-1:0] src1_tag, src2_tag;
    logic             src1_rdy, src2_rdy;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid    <= 1'b0;
            src1_rdy <= 1'b0;
            src2_rdy <= 1'b0;
        end else if (alloc) begin
            valid    <= 1'b1;
            // a writeback arriving in the dispatch cycle would otherwise be missed
            src1_rdy <= disp_src1_rdy || (wb_valid && disp_src1_tag == wb_tag);
            src2_rdy <= disp_src2_rdy || (wb_valid && disp_src2_tag == wb_tag);
        end else begin
            if (issue)
                valid <= 1'b0;
            if (valid && wb_valid && src1_tag == wb_tag)
                src1_rdy <= 1'b1;
            if (valid && wb_valid && src2_tag == wb_tag)
                src2_rdy <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (alloc) begin
            payload  <= disp_payload;
            src1_tag <= disp_src1_tag;
            src2_tag <= disp_src2_tag;
        end
    end

    assign ready = valid && src1_rdy && src2_rdy;
endmodule

module issue_queue_slots #(
    parameter int NUM_ENTRIES = 4,
    parameter int TAG_W       = 6,
    parameter int PAYLOAD_W   = 32,
    localparam int IDX_W      = $clog2(NUM_ENTRIES)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   disp_valid,
    output logic                   disp_ready,
    input  logic [PAYLOAD_W-1:0]   disp_payload,
    input  logic [TAG_W-1:0]       disp_src1_tag,
    input  logic                   disp_src1_rdy,
    input  logic [TAG_W-1:0]       disp_src2_tag,
    input  logic                   disp_src2_rdy,
    input  logic                   wb_valid,
    input  logic [TAG_W-1:0]       wb_tag,
    output logic                   alloc_update,
    output logic [IDX_W-1:0]       alloc_row,
    output logic [NUM_ENTRIES-1:0] valid_entries,
    output logic [NUM_ENTRIES-1:0] ready_entries,
    input  logic [NUM_ENTRIES-1:0] grant,
    output logic                   issue_valid,
    input  logic                   issue_ready,
    output logic [PAYLOAD_W-1:0]   issue_payload,
    output logic [IDX_W-1:0]       issue_slot,
    output logic [IDX_W:0]         occupancy
);
    logic [NUM_ENTRIES-1:0]                valid, rdy, eff;
    logic [NUM_ENTRIES-1:0][PAYLOAD_W-1:0] payload;
    logic [IDX_W-1:0]                      free_idx, gnt_idx;
    logic [IDX_W:0]                        occ;
    logic                                  alloc_fire, issue_fire;

    always_comb begin
        free_idx = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--)
            if (!valid[i]) free_idx = IDX_W'(i);
    end

    // lowest set bit keeps a multi-hot grant deterministic
    always_comb begin
        gnt_idx = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--)
            if (eff[i]) gnt_idx = IDX_W'(i);
    end

    assign valid_entries = reset ? '0 : valid;
    assign ready_entries = reset ? '0 : rdy;
    assign disp_ready    = !reset && !(&valid);
    assign alloc_fire    = disp_valid && disp_ready;
    assign alloc_update  = alloc_fire;
    assign alloc_row     = free_idx;
    assign eff           = grant & ready_entries;
    assign issue_valid   = |eff;
    assign issue_fire    = issue_valid && issue_ready;
    assign issue_slot    = gnt_idx;
    assign issue_payload = payload[gnt_idx];
    assign occupancy     = reset ? '0 : occ;

    for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_slot
        issue_queue_slot #(.TAG_W(TAG_W), .PAYLOAD_W(PAYLOAD_W)) u_slot (
            .clk           (clk),
            .reset         (reset),
            .alloc         (alloc_fire && free_idx == IDX_W'(g)),
            .issue         (issue_fire && gnt_idx == IDX_W'(g)),
            .disp_payload  (disp_payload),
            .disp_src1_tag (disp_src1_tag),
            .disp_src1_rdy (disp_src1_rdy),
            .disp_src2_tag (disp_src2_tag),
            .disp_src2_rdy (disp_src2_rdy),
            .wb_valid      (wb_valid),
            .wb_tag        (wb_tag),
            .valid         (valid[g]),
            .ready         (rdy[g]),
            .payload       (payload[g])
        );
    end

    always_ff @(posedge clk) begin
        if (reset)
            occ <= '0;
        else if (alloc_fire && !issue_fire)
            occ <= occ + 1'b1;
        else if (!alloc_fire && issue_fire)
            occ <= occ - 1'b1;
    end
endmodule

// File: tb/tb_issue_queue_slots.sv
// Directed bench: scoreboard queues for allocations and issues, checked by a
// negedge monitor; state vectors checked inline against hand-computed values.
module tb_issue_queue_slots;
    logic        clk = 0, reset = 1;
    logic        disp_valid = 0, disp_ready;
    logic [31:0] disp_payload = 0;
    logic [5:0]  disp_src1_tag = 0, disp_src2_tag = 0, wb_tag = 0;
    logic        disp_src1_rdy = 0, disp_src2_rdy = 0, wb_valid = 0;
    logic        alloc_update;
    logic [1:0]  alloc_row, issue_slot;
    logic [3:0]  valid_entries, ready_entries, grant = 0;
    logic        issue_valid, issue_ready = 0;
    logic [31:0] issue_payload;
    logic [2:0]  occupancy;

    int vectors = 0, miscompares = 0;
    logic [1:0]  exp_alloc[$];
    logic [33:0] exp_issue[$];

    issue_queue_slots #(.NUM_ENTRIES(4), .TAG_W(6), .PAYLOAD_W(32)) dut (
        .clk(clk), .reset(reset), .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_payload(disp_payload), .disp_src1_tag(disp_src1_tag),
        .disp_src1_rdy(disp_src1_rdy), .disp_src2_tag(disp_src2_tag),
        .disp_src2_rdy(disp_src2_rdy), .wb_valid(wb_valid), .wb_tag(wb_tag),
        .alloc_update(alloc_update), .alloc_row(alloc_row),
        .valid_entries(valid_entries), .ready_entries(ready_entries), .grant(grant),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_payload(issue_payload), .issue_slot(issue_slot), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && alloc_update) begin
            if (exp_alloc.size() == 0) check("alloc_unexpected", 34'(alloc_row), 34'h3ffff);
            else check("alloc_row", 34'(alloc_row), 34'(exp_alloc.pop_front()));
        end
        if (!reset && issue_valid && issue_ready) begin
            if (exp_issue.size() == 0) check("issue_unexpected", {issue_slot, issue_payload}, 34'h3ffff);
            else check("issue_slot_payload", {issue_slot, issue_payload}, exp_issue.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic dispatch(input logic [31:0] p, input logic [5:0] t1, input logic r1,
                            input logic [5:0] t2, input logic r2, input logic [1:0] row);
        disp_valid = 1; disp_payload = p;
        disp_src1_tag = t1; disp_src1_rdy = r1; disp_src2_tag = t2; disp_src2_rdy = r2;
        exp_alloc.push_back(row);
        tick();
        disp_valid = 0;
    endtask

    task automatic issue(input logic [3:0] g, input logic [1:0] slot, input logic [31:0] p);
        grant = g; issue_ready = 1;
        exp_issue.push_back({slot, p});
        tick();
        grant = 0; issue_ready = 0;
    endtask

    initial begin
        // reset with stray grant/ready asserted: everything must stay quiet
        grant = 4'b1111; issue_ready = 1;
        tick(); tick(); #1;
        check("rst_disp_ready", 34'(disp_ready), 0);
        check("rst_occupancy", 34'(occupancy), 0);
        check("rst_valid", 34'(valid_entries), 0);
        check("rst_issue_valid", 34'(issue_valid), 0);
        grant = 0; issue_ready = 0;
        reset = 0; tick(); #1;
        check("empty_disp_ready", 34'(disp_ready), 1);

        // fill all four slots
        for (int i = 0; i < 4; i++) dispatch(32'hA0 + i, 6'd1, 1, 6'd2, 1, 2'(i));
        #1;
        check("full_occ", 34'(occupancy), 4);
        check("full_disp_ready", 34'(disp_ready), 0);
        check("full_valid", 34'(valid_entries), 34'b1111);
        check("full_ready", 34'(ready_entries), 34'b1111);
        disp_valid = 1; #1;
        check("full_no_alloc", 34'(alloc_update), 0);
        disp_valid = 0;

        // issue slot 1, refill lands in slot 1
        issue(4'b0010, 2'd1, 32'hA1); #1;
        check("post_issue_valid", 34'(valid_entries), 34'b1101);
        check("post_issue_occ", 34'(occupancy), 3);
        check("post_issue_disp_ready", 34'(disp_ready), 1);
        dispatch(32'hB0, 6'd1, 1, 6'd2, 1, 2'd1);
        issue(4'b0001, 2'd0, 32'hA0);
        issue(4'b1000, 2'd3, 32'hA3); #1;
        check("occ_two", 34'(occupancy), 2);

        // wakeup via broadcast; a non-matching tag must not wake
        dispatch(32'hC0, 6'd5, 0, 6'd9, 0, 2'd0); #1;
        check("wake_valid0", 34'(valid_entries[0]), 1);
        check("wake_notready", 34'(ready_entries[0]), 0);
        grant = 4'b0001; issue_ready = 1; #1;
        check("grant_nonready_ignored", 34'(issue_valid), 0);
        grant = 0; issue_ready = 0;
        wb_valid = 1; wb_tag = 6'd5; tick(); wb_valid = 0; #1;
        check("wake_partial", 34'(ready_entries[0]), 0);
        wb_valid = 1; wb_tag = 6'd9; tick(); wb_valid = 0; #1;
        check("wake_full", 34'(ready_entries[0]), 1);

        // dispatch-cycle bypass
        wb_valid = 1; wb_tag = 6'd5;
        dispatch(32'hC3, 6'd5, 0, 6'd2, 1, 2'd3);
        wb_valid = 0; #1;
        check("bypass_ready", 34'(ready_entries[3]), 1);

        // back-pressure with multi-hot grant: lowest of slots 2,3 wins
        grant = 4'b1100; issue_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_issue_valid", 34'(issue_valid), 1);
            check("bp_issue_slot_payload", {issue_slot, issue_payload}, {2'd2, 32'hA2});
            tick();
        end
        #1;
        check("bp_still_valid", 34'(valid_entries[2]), 1);
        check("bp_occ", 34'(occupancy), 4);
        issue(4'b1100, 2'd2, 32'hA2); #1;
        check("bp_freed", 34'(valid_entries[2]), 0);
        check("bp_occ_dec", 34'(occupancy), 3);

        // simultaneous dispatch and issue at occupancy 2
        issue(4'b1000, 2'd3, 32'hC3); #1;
        check("sim_occ_before", 34'(occupancy), 2);
        grant = 4'b0001; issue_ready = 1;
        exp_issue.push_back({2'd0, 32'hC0});
        dispatch(32'hD0, 6'd1, 1, 6'd2, 1, 2'd2);
        grant = 0; issue_ready = 0; #1;
        check("sim_occ", 34'(occupancy), 2);
        check("sim_valid", 34'(valid_entries), 34'b0110);

        // reset with three valid slots and a live issue
        dispatch(32'hE0, 6'd1, 1, 6'd2, 1, 2'd0); #1;
        check("pre_rst_valid", 34'(valid_entries), 34'b0111);
        grant = 4'b0010; issue_ready = 1; disp_valid = 1; reset = 1; #1;
        check("rst_mid_issue_valid", 34'(issue_valid), 0);
        check("rst_mid_alloc", 34'(alloc_update), 0);
        tick();
        grant = 0; issue_ready = 0; disp_valid = 0; #1;
        check("rst2_valid", 34'(valid_entries), 0);
        check("rst2_occ", 34'(occupancy), 0);
        check("rst2_ready", 34'(ready_entries), 0);
        reset = 0; tick();
        dispatch(32'hF0, 6'd1, 1, 6'd2, 1, 2'd0); #1;
        check("post_rst_valid", 34'(valid_entries), 34'b0001);
        check("post_rst_occ", 34'(occupancy), 1);

        tick();
        check("alloc_queue_drained", 34'(exp_alloc.size()), 0);
        check("issue_queue_drained", 34'(exp_issue.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/issue_queue_slots.md
Name: issue_queue_slots

Overview:
Payload and status storage for one issue-unit reservation station; it is the producer and consumer side of the age-matrix selector.
- Accepts dispatched micro-ops, allocates free slots and tracks source-operand readiness via writeback tag broadcast.
- Drives allocation, valid and ready vectors to the age matrix.
- Takes back the age matrix's one-hot grant and hands the granted entry to execute over a valid/ready handshake, then frees the slot.

Parameters:
NUM_ENTRIES, 4, number of reservation-station slots (power of 2, >=2)
TAG_W, 6, physical register tag width
PAYLOAD_W, 32, opaque micro-op payload width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
disp_valid  in  1  dispatch request
disp_ready  out  1  a free slot exists
disp_payload  in  PAYLOAD_W  micro-op payload
disp_src1_tag  in  TAG_W  source 1 tag
disp_src1_rdy  in  1  source 1 already available
disp_src2_tag  in  TAG_W  source 2 tag
disp_src2_rdy  in  1  source 2 already available
wb_valid  in  1  writeback broadcast valid
wb_tag  in  TAG_W  writeback tag
alloc_update  out  1  pulse: age matrix must record a new youngest entry
alloc_row  out  $clog2(NUM_ENTRIES)  slot index being allocated
valid_entries  out  NUM_ENTRIES  registered slot-valid bits
ready_entries  out  NUM_ENTRIES  valid and both sources ready
grant  in  NUM_ENTRIES  one-hot oldest-ready selection from age matrix
issue_valid  out  1  issued entry presented
issue_ready  in  1  execute accepts
issue_payload  out  PAYLOAD_W  payload of granted slot
issue_slot  out  $clog2(NUM_ENTRIES)  index of granted slot
occupancy  out  $clog2(NUM_ENTRIES)+1  number of valid slots

Behaviour:
- Per-slot state: valid, payload, src1/src2 tag, src1/src2 ready bit.
- Reset: all valid and ready bits cleared, occupancy=0. While reset is high, disp_ready=0, alloc_update=0, issue_valid=0 and all vectors are 0. Payload contents are don't-care. Reset mid-transfer discards everything.
- disp_ready = any slot invalid, computed from registered state only. A slot freed this cycle is not reusable until the next cycle.
- Free slot choice: lowest-index invalid slot.
- Allocation fires when disp_valid && disp_ready. In the same cycle, combinationally: alloc_update=1 and alloc_row=chosen slot. At the next edge the slot's valid is set and payload, tags and ready bits are written.
- Wakeup: when wb_valid and a valid slot's srcN_tag == wb_tag, srcN ready is set at the next edge.
- Dispatch bypass: a dispatching source whose tag equals wb_tag while wb_valid=1 is written as ready.
- Ready bits never clear while a slot is valid.
- ready_entries[i] = valid[i] & src1_rdy[i] & src2_rdy[i], from registered state.
- Issue: eff = grant & ready_entries.
  - issue_valid = |eff.
  - issue_slot / issue_payload select the lowest set bit of eff, which gives defined behaviour for an illegal multi-hot grant.
  - A grant on a non-ready or invalid slot is ignored.
- Issue is combinational, zero latency from grant. On issue_valid && issue_ready, the slot's valid clears at the next edge.
- Back-pressure: if issue_ready=0 the entry stays valid, and the grant may change next cycle with no side effects.
- Occupancy: +1 on allocation, -1 on issue, unchanged when both occur in the same cycle. It never exceeds NUM_ENTRIES and never underflows.
- Full: occupancy==NUM_ENTRIES implies disp_ready=0. Empty: valid_entries=0, issue_valid=0.

Test Plan:
- Reset, then dispatch 4 micro-ops, all sources ready, payloads 0xA0..0xA3 -> alloc_row 0,1,2,3 with an alloc_update pulse each; occupancy=4; disp_ready=0 on the 5th cycle.
- Full queue, grant=0010, issue_ready=1 for 1 cycle -> issue_payload=0xA1, issue_slot=1; next cycle valid_entries=1101, occupancy=3, disp_ready=1; the next dispatch lands in slot 1.
- Dispatch src1_tag=5 not ready, src2 ready -> ready_entries bit=0; wb_valid with wb_tag=5 -> bit=1 one cycle later. Repeat with dispatch and wb_tag=5 in the same cycle -> ready immediately after allocation.
- Grant on ready slot 2 with issue_ready=0 for 3 cycles -> issue_valid held and slot stays valid; issue_ready=1 -> slot freed, occupancy decrements by 1.
- Occupancy=2 with simultaneous dispatch and issue -> occupancy stays 2; freed slot not chosen as alloc_row that cycle.
- Assert reset with 3 valid slots and issue_valid=1 -> next cycle all outputs 0, occupancy=0; first dispatch after release goes to slot 0.
